sd_sector_buffer: RTL and testbench

//  512-byte sector buffer and command sequencer directly upstream of sd_card_controller.

---
 rtl/sd_buf_pkg.sv | 26 ++
 rtl/sd_sector_ram.sv | 44 ++++
 rtl/sd_sector_buffer.sv | 160 ++++++++++++++++
 tb/tb_sd_sector_buffer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_buf_pkg.sv
// Shared types and defaults for the SD sector buffer: sequencer states,
// error codes, operation encoding.
package sd_buf_pkg;

    localparam int SECTOR_BYTES_DEF = 512;
    localparam int ACK_TIMEOUT_DEF  = 1000;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_ACK     = 2'b01,
        ERR_SHORT   = 2'b10,
        ERR_OVERRUN = 2'b11
    } err_e;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_ACK,
        XFER,
        DONE
    } state_e;

endpackage

// File: rtl/sd_sector_ram.sv
// True dual-port sector RAM: port A serves the host, port B the controller.
// Both read ports are registered (1-cycle latency) and clear on reset; the array itself does not.
module sd_sector_ram
    import sd_buf_pkg::*;
#(
    parameter int  DEPTH = SECTOR_BYTES_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] a_addr,
    input  logic [7:0]    a_wdata,
    input  logic          a_we,
    output logic [7:0]    a_rdata,
    input  logic [AW-1:0] b_addr,
    input  logic [7:0]    b_wdata,
    input  logic          b_we,
    output logic [7:0]    b_rdata
);

    logic [7:0] mem [DEPTH];
    logic [7:0] a_rdata_q;
    logic [7:0] b_rdata_q;

    // The sequencer guarantees the two ports never write in the same cycle.
    always_ff @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_wdata;
        if (b_we) mem[b_addr] <= b_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            a_rdata_q <= mem[a_addr];
            b_rdata_q <= mem[b_addr];
        end
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/sd_sector_buffer.sv
// Sector buffer and command sequencer in front of sd_card_controller:
// launches one read/write per host_start, moves bytes, and reports ok/timeout/short/overrun.
module sd_sector_buffer
    import sd_buf_pkg::*;
#(
    parameter int  SECTOR_BYTES = SECTOR_BYTES_DEF,
    parameter int  ACK_TIMEOUT  = ACK_TIMEOUT_DEF,
    localparam int AW           = $clog2(SECTOR_BYTES)
) (
    input  logic          clk,
    input  logic          btn,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    input  logic          host_we,
    output logic [7:0]    host_rdata,
    input  logic          host_start,
    input  logic          host_op,
    input  logic [25:0]   host_sector,
    output logic          busy_o,
    output logic          done_o,
    output logic [1:0]    err_o,
    output logic          op_code,
    output logic          execute,
    output logic [25:0]   sector_address,
    output logic [7:0]    outgoing_byte,
    input  logic [7:0]    incoming_byte,
    input  logic          finished_byte,
    input  logic          finished_sector,
    input  logic          busy
);

    localparam int             WDW     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [AW-1:0]  IDX_MAX = AW'(SECTOR_BYTES - 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(ACK_TIMEOUT - 1);

    state_e         state_q, state_d;
    err_e           err_q, err_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           exec_q, exec_d;
    logic           op_q, op_d;
    logic [25:0]    sec_q, sec_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic           complete_q, complete_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic           ram_we_b;

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        exec_d     = 1'b0;
        op_d       = op_q;
        sec_d      = sec_q;
        idx_d      = idx_q;
        complete_d = complete_q;
        wd_d       = wd_q;
        ram_we_b   = 1'b0;
        case (state_q)
            IDLE: begin
                if (host_start && !busy) begin
                    op_d       = host_op;
                    sec_d      = host_sector;
                    err_d      = ERR_OK;
                    idx_d      = '0;
                    complete_d = 1'b0;
                    exec_d     = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                // Count starts at 1 so DONE lands exactly ACK_TIMEOUT cycles after execute.
                wd_d    = WDW'(1);
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (busy) begin
                    state_d = XFER;
                end else if (wd_q >= WD_LAST) begin
                    err_d   = ERR_ACK;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            XFER: begin
                if (finished_byte) begin
                    if (complete_q) begin
                        err_d = ERR_OVERRUN;
                    end else begin
                        ram_we_b = (op_q == OP_READ);
                        if (idx_q == IDX_MAX) complete_d = 1'b1;
                        else                  idx_d      = idx_q + AW'(1);
                    end
                end
                // Completeness is judged after any same-cycle byte has been counted.
                if (finished_sector) begin
                    if (!complete_d) err_d = ERR_SHORT;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge btn) begin
        if (btn) begin
            state_q    <= IDLE;
            err_q      <= ERR_OK;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            exec_q     <= 1'b0;
            op_q       <= OP_READ;
            sec_q      <= '0;
            idx_q      <= '0;
            complete_q <= 1'b0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            exec_q     <= exec_d;
            op_q       <= op_d;
            sec_q      <= sec_d;
            idx_q      <= idx_d;
            complete_q <= complete_d;
            wd_q       <= wd_d;
        end
    end

    sd_sector_ram #(.DEPTH(SECTOR_BYTES)) u_ram (
        .clk     (clk),
        .rst     (btn),
        .a_addr  (host_addr),
        .a_wdata (host_wdata),
        .a_we    (host_we && !busy_q),
        .a_rdata (host_rdata),
        .b_addr  (idx_q),
        .b_wdata (incoming_byte),
        .b_we    (ram_we_b),
        .b_rdata (outgoing_byte)
    );

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign op_code        = op_q;
    assign execute        = exec_q;
    assign sector_address = sec_q;

endmodule

// File: tb/tb_sd_sector_buffer.sv
// Randomized bench for sd_sector_buffer: a behavioural controller drives byte transfers,
// a byte-array model of the sector predicts RAM contents, outgoing bytes and error codes.
module tb_sd_sector_buffer;

    localparam int NB = 512;
    localparam int TO = 1000;

    logic        clk = 1'b0;
    logic        btn = 1'b0;
    logic [8:0]  host_addr = '0;
    logic [7:0]  host_wdata = '0;
    logic        host_we = 1'b0;
    logic [7:0]  host_rdata;
    logic        host_start = 1'b0;
    logic        host_op = 1'b0;
    logic [25:0] host_sector = '0;
    logic        busy_o, done_o, op_code, execute;
    logic [1:0]  err_o;
    logic [25:0] sector_address;
    logic [7:0]  outgoing_byte;
    logic [7:0]  incoming_byte = '0;
    logic        finished_byte = 1'b0;
    logic        finished_sector = 1'b0;
    logic        busy = 1'b0;

    sd_sector_buffer #(.SECTOR_BYTES(NB), .ACK_TIMEOUT(TO)) dut (
        .clk             (clk),
        .btn             (btn),
        .host_addr       (host_addr),
        .host_wdata      (host_wdata),
        .host_we         (host_we),
        .host_rdata      (host_rdata),
        .host_start      (host_start),
        .host_op         (host_op),
        .host_sector     (host_sector),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .op_code         (op_code),
        .execute         (execute),
        .sector_address  (sector_address),
        .outgoing_byte   (outgoing_byte),
        .incoming_byte   (incoming_byte),
        .finished_byte   (finished_byte),
        .finished_sector (finished_sector),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, n_exec = 0, n_done = 0, exec_cyc = 0, done_cyc = 0;
    logic [7:0] model_ram [NB];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (execute) begin
            n_exec   <= n_exec + 1;
            exec_cyc <= cyc;
        end
        if (done_o) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Error the controller protocol should produce for a sector of n finished bytes.
    function automatic logic [1:0] exp_err(input int n);
        if (n > NB) return 2'b11;
        if (n < NB) return 2'b10;
        return 2'b00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int a, input logic [7:0] d);
        host_addr  = 9'(a);
        host_wdata = d;
        host_we    = 1'b1;
        tick();
        host_we    = 1'b0;
    endtask

    task automatic host_read(input int a, output logic [7:0] d);
        host_addr = 9'(a);
        tick();
        d = host_rdata;
    endtask

    task automatic check_ram(input string tag, input int upto);
        logic [7:0] d;
        for (int k = 0; k < upto; k++) begin
            host_read(k, d);
            chk(tag, 32'(d), 32'(model_ram[k]));
        end
    endtask

    task automatic start(input logic op, input logic [25:0] sec);
        host_op     = op;
        host_sector = sec;
        host_start  = 1'b1;
        tick();
        host_start  = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int i = 0;
        while (n_done == d0 && i < budget) begin
            tick();
            i++;
        end
        chk("done_seen", n_done - d0, 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_fs);
        incoming_byte   = b;
        finished_byte   = 1'b1;
        finished_sector = with_fs;
        tick();
        finished_byte   = 1'b0;
        finished_sector = 1'b0;
        repeat (1 + $urandom_range(0, 2)) tick();
    endtask

    task automatic run_op(input logic op, input logic [25:0] sec, input int n,
                          input bit same_fs, input bit rnd, input bit poke);
        int e0 = n_exec;
        int d0 = n_done;
        logic [7:0] b;
        start(op, sec);
        busy = 1'b1;
        repeat (3) tick();
        chk("sector_address", 32'(sector_address), 32'(sec));
        chk("op_code", 32'(op_code), 32'(op));
        chk("busy_o_run", 32'(busy_o), 1);
        chk("err_clr", 32'(err_o), 0);
        for (int k = 0; k < n; k++) begin
            if (op && k < NB) chk("outgoing_byte", 32'(outgoing_byte), 32'(model_ram[k]));
            if (poke && k == 10) begin
                host_op     = ~op;
                host_sector = sec ^ 26'h155;
                host_start  = 1'b1;
                tick();
                host_start  = 1'b0;
                host_write(20, ~model_ram[20]);
                tick();
            end
            b = rnd ? 8'($urandom) : 8'(k);
            send_byte(b, same_fs && (k == n - 1));
            if (!op && k < NB) model_ram[k] = b;
        end
        chk("sector_held", 32'(sector_address), 32'(sec));
        if (!same_fs) begin
            finished_sector = 1'b1;
            tick();
            finished_sector = 1'b0;
        end
        busy = 1'b0;
        wait_done(d0, 20);
        repeat (3) tick();
        chk("done_once", n_done - d0, 1);
        chk("exec_once", n_exec - e0, 1);
        chk("busy_o_idle", 32'(busy_o), 0);
        chk("err_o", 32'(err_o), 32'(exp_err(n)));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int e0, d0;
        logic [7:0] b;
        #2 btn = 1'b1;
        repeat (3) tick();
        chk("rst_busy_o", 32'(busy_o), 0);
        chk("rst_done_o", 32'(done_o), 0);
        chk("rst_execute", 32'(execute), 0);
        chk("rst_op_code", 32'(op_code), 0);
        chk("rst_err_o", 32'(err_o), 0);
        chk("rst_sector", 32'(sector_address), 0);
        chk("rst_outgoing", 32'(outgoing_byte), 0);
        chk("rst_rdata", 32'(host_rdata), 0);
        @(negedge clk);
        btn = 1'b0;
        tick();

        // Read, data = index, separate finished_sector.
        run_op(1'b0, 26'h000123, NB, 1'b0, 1'b0, 1'b0);
        check_ram("rd_idx", NB);

        // Read, random data, finished_sector with the last byte.
        run_op(1'b0, 26'($urandom), NB, 1'b1, 1'b1, 1'b0);
        check_ram("rd_rand", NB);

        // Write: buffer holds ~k; host activity mid-transfer must not disturb anything.
        for (int k = 0; k < NB; k++) begin
            model_ram[k] = ~8'(k);
            host_write(k, model_ram[k]);
        end
        run_op(1'b1, 26'h0000456, NB, 1'b0, 1'b1, 1'b1);
        check_ram("wr_kept", NB);

        // Ack timeout.
        d0 = n_done;
        start(1'b0, 26'h2000042);
        wait_done(d0, TO + 20);
        chk("timeout_latency", done_cyc - exec_cyc, TO);
        chk("timeout_err", 32'(err_o), 1);
        repeat (2) tick();
        chk("timeout_busy_o", 32'(busy_o), 0);

        // Start while controller busy is ignored.
        busy = 1'b1;
        e0 = n_exec;
        start(1'b0, 26'h0000999);
        repeat (3) tick();
        chk("start_ctrl_busy", n_exec - e0, 0);
        chk("start_ctrl_busy_o", 32'(busy_o), 0);
        busy = 1'b0;
        tick();

        run_op(1'b0, 26'($urandom), 100, 1'b0, 1'b1, 1'b0);
        check_ram("short", 100);
        run_op(1'b0, 26'($urandom), NB + 1, 1'b0, 1'b1, 1'b0);
        check_ram("overrun", NB);

        // Reset mid-transfer.
        d0 = n_done;
        start(1'b0, 26'h0000777);
        busy = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < 50; k++) begin
            b = 8'($urandom);
            send_byte(b, 1'b0);
            model_ram[k] = b;
        end
        btn = 1'b1;
        #2;
        chk("midrst_busy_o", 32'(busy_o), 0);
        chk("midrst_sector", 32'(sector_address), 0);
        chk("midrst_outgoing", 32'(outgoing_byte), 0);
        chk("midrst_rdata", 32'(host_rdata), 0);
        @(negedge clk);
        btn  = 1'b0;
        busy = 1'b0;
        repeat (3) tick();
        chk("midrst_no_done", n_done - d0, 0);
        check_ram("midrst_kept", 50);
        run_op(1'b0, 26'($urandom), NB, 1'b0, 1'b1, 1'b0);
        check_ram("after_rst", NB);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
